// File: rtl/imem_loader.sv
// Program loader for a small CPU: streams prog_len words into instruction
// memory, pulses start, then counts CPU run cycles until done.
module imem_loader #(
  parameter int AW = 8,
  parameter int IW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_go,
  input  logic [AW:0]   prog_len,
  input  logic          in_valid,
  input  logic [IW-1:0] in_data,
  output logic          in_ready,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [IW-1:0] im_wdata,
  output logic          start,
  input  logic          done,
  output logic          busy,
  output logic          finished,
  output logic          err,
  output logic [15:0]   run_cycles,
  output logic [2:0]    dbg_state
);

  // Word handshake: a word transfers on a rising edge where in_valid and
  // in_ready are both high; in_valid may drop at any time and the loader waits.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_t        state_q;
  state_t        state_d;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_inc;
  logic [AW:0]   len_q;
  logic [15:0]   run_q;
  logic          err_q;

  logic          len_ok;
  logic          go_legal;
  logic          go_illegal;
  logic          accept;
  logic          run_tick;

  // One extra counter bit lets a full-depth load reach DEPTH without wrapping.
  assign cnt_inc = cnt_q + 1'b1;
  assign len_ok  = (prog_len != '0) && (prog_len <= DEPTH);

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    start      = 1'b0;
    busy       = 1'b0;
    finished   = 1'b0;
    go_legal   = 1'b0;
    go_illegal = 1'b0;
    accept     = 1'b0;
    run_tick   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        finished = (state_q == S_DONE);
        if (load_go) begin
          if (len_ok) begin
            go_legal = 1'b1;
            state_d  = S_LOAD;
          end else begin
            go_illegal = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        accept   = in_valid;
        if (in_valid && (cnt_inc == len_q)) begin
          state_d = S_START;
        end
      end
      S_START: begin
        start   = 1'b1;
        busy    = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (done) begin
          state_d = S_DONE;
        end else begin
          run_tick = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign im_we      = in_valid & in_ready;
  assign im_addr    = cnt_q[AW-1:0];
  assign im_wdata   = in_data;
  assign err        = err_q;
  assign run_cycles = run_q;
  assign dbg_state  = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      len_q <= '0;
      err_q <= 1'b0;
    end else if (go_legal) begin
      cnt_q <= '0;
      len_q <= prog_len;
      err_q <= 1'b0;
    end else begin
      if (go_illegal) begin
        err_q <= 1'b1;
      end
      if (accept) begin
        cnt_q <= cnt_inc;
      end
    end
  end

  // Run counter saturates rather than wrapping on very long programs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= '0;
    end else if (go_legal) begin
      run_q <= '0;
    end else if (run_tick && (run_q != 16'hFFFF)) begin
      run_q <= run_q + 16'd1;
    end
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL take parameter AW, default 8: instruction-memory address width, so DEPTH = 2^AW words.
REQ-002 SHALL take parameter IW, default 9: instruction word width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port load_go, input, 1 bit: request to begin a program load.
REQ-006 SHALL have port prog_len, input, AW+1 bits: number of words to load; sampled with load_go.
REQ-007 SHALL have port in_valid, input, 1 bit: an instruction word is offered.
REQ-008 SHALL have port in_data, input, IW bits: the offered instruction word.
REQ-009 SHALL have port in_ready, output, 1 bit: loader accepts a word this cycle.
REQ-010 SHALL have port im_we, output, 1 bit: instruction-memory write enable.
REQ-011 SHALL have port im_addr, output, AW bits: instruction-memory write address.
REQ-012 SHALL have port im_wdata, output, IW bits: instruction-memory write data.
REQ-013 SHALL have port start, output, 1 bit: CPU start pulse.
REQ-014 SHALL have port done, input, 1 bit: CPU completion flag.
REQ-015 SHALL have port busy, output, 1 bit: high in LOAD, START and RUN.
REQ-016 SHALL have port finished, output, 1 bit: high in DONE.
REQ-017 SHALL have port err, output, 1 bit: sticky error for an illegal prog_len.
REQ-018 SHALL have port run_cycles, output, 16 bits: cycles the CPU ran.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, START, RUN and DONE.
REQ-020 IDLE: load_go=1 with 1<=prog_len<=DEPTH SHALL latch prog_len, clear err, run_cycles, finished and the address counter, and enter LOAD next cycle.
REQ-021 IDLE or DONE: load_go=1 with prog_len=0 or prog_len>DEPTH SHALL set err=1 and enter or remain IDLE; no memory write.
REQ-022 DONE: a legal load_go SHALL behave as in REQ-020 (reload).
REQ-023 in_ready SHALL be 1 only in LOAD; it is 0 in every other state.
REQ-024 im_we SHALL equal in_valid AND in_ready, combinationally, in the same cycle.
REQ-025 im_addr SHALL equal the address counter, and im_wdata SHALL equal in_data.
REQ-026 Each accepted word SHALL increment the address counter by 1.
REQ-027 The word accepted at address prog_len-1 SHALL move the FSM to START next cycle.
REQ-028 in_valid=0 in LOAD SHALL stall without timeout; the counter holds.
REQ-029 START SHALL last exactly one cycle with start=1, then go to RUN; start=0 in all other states.
REQ-030 RUN: run_cycles SHALL increment by 1 each cycle that done=0, saturating at 16'hFFFF.
REQ-031 RUN: done=1 SHALL move the FSM to DONE next cycle without incrementing on that cycle; run_cycles then freezes.
REQ-032 done SHALL be ignored outside RUN.
REQ-033 load_go SHALL be ignored in LOAD, START and RUN.
REQ-034 prog_len=DEPTH SHALL load addresses 0..DEPTH-1; the counter SHALL NOT wrap to 0 before the FSM leaves LOAD.

Reset
REQ-035 rst_n=0 SHALL immediately force: state IDLE, counter 0, run_cycles 0, err 0, start 0, finished 0, busy 0, in_ready 0, im_we 0.
REQ-036 Reset in the middle of LOAD or RUN SHALL abandon the operation; words already written stay in memory and no start is issued.
REQ-037 After rst_n deasserts, the first legal load_go SHALL behave as in REQ-020.

Verification
REQ-038 Load prog_len=3 with words 9'h0AC, 9'h123, 9'h1FF on back-to-back valid -> writes to addr 0,1,2; start pulses exactly 1 cycle, on the cycle after the third write.
REQ-039 Load prog_len=2 with in_valid low for 4 cycles between the words -> addr holds at 1 during the gap; exactly 2 writes; a single start pulse.
REQ-040 After start, drive done=1 after 7 RUN cycles -> run_cycles=7; finished=1; busy=0; later done toggles leave run_cycles unchanged.
REQ-041 load_go with prog_len=0, then prog_len=257 (AW=8) -> err=1 each time; state IDLE; no im_we; a following load of prog_len=1 clears err.
REQ-042 prog_len=256 -> 256 writes at addr 0..255 with no write at a wrapped address 0; a single start pulse.
REQ-043 Assert rst_n=0 mid-LOAD after 2 of 5 words -> im_we and in_ready drop the same cycle; the FSM is IDLE; start never asserts.
